// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory arbiter (FSM states, grant owner, data word).
package cpu_types_pkg;
  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IDONE, DDONE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: counts busy cycles and flags a RAM access that never sees ramready.
module mem_arb_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_expired,
  output logic o_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  // The counter idles at zero outside busy states, so every busy entry starts from zero.
  always_ff @(posedge clk) begin
    r_cnt <= (rst | ~i_busy | o_expired) ? '0 : r_cnt + 1'b1;
    r_err <= rst ? 1'b0 : r_err | o_expired;
  end
  assign o_expired = i_busy & ~i_ready & (r_cnt == CW'(TIMEOUT - 1));
  assign o_err = r_err;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one RAM port between fetch and data requesters.
// Defining MEMARB_TIMEOUT_EN adds a ramready timeout and a sticky err output.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              halted
`ifdef MEMARB_TIMEOUT_EN
  , output logic            err
`endif
);
  arb_state_t r_state, w_next;
  grant_t r_last;
  logic r_halt_seen, r_ramren, r_ramwen;
  logic [ADDR_W-1:0] r_ramaddr;
  logic [DATA_W-1:0] r_ramstore, r_iload, r_dload;
  logic w_dreq, w_ireq, w_gnt_d, w_gnt_i, w_busy, w_expired;
  assign w_dreq  = dREN | dWEN;
  assign w_ireq  = iREN & ~r_halt_seen;
  assign w_gnt_d = w_dreq & (~w_ireq | (r_last == GRANT_I));
  assign w_gnt_i = w_ireq & ~w_gnt_d;
  assign w_busy  = (r_state == IBUSY) | (r_state == DBUSY);
`ifdef MEMARB_TIMEOUT_EN
  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(CLK), .rst(RST), .i_busy(w_busy), .i_ready(ramready), .o_expired(w_expired), .o_err(err)
  );
`else
  // Without the timeout a busy state waits for ramready indefinitely.
  assign w_expired = (TIMEOUT < 0);
`endif
  always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_gnt_d ? DBUSY : w_gnt_i ? IBUSY : IDLE;
      IBUSY:   w_next = ramready ? IDONE : w_expired ? IDLE : IBUSY;
      DBUSY:   w_next = ramready ? DDONE : w_expired ? IDLE : DBUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last      <= GRANT_I;
      r_halt_seen <= 1'b0;
      r_ramren    <= 1'b0;
      r_ramwen    <= 1'b0;
      r_ramaddr   <= '0;
      r_ramstore  <= '0;
      r_iload     <= '0;
      r_dload     <= '0;
    end else begin
      r_halt_seen <= r_halt_seen | halt;
      if (r_state == IDLE && w_gnt_d) begin
        r_last     <= GRANT_D;
        r_ramren   <= ~dWEN;
        r_ramwen   <= dWEN;
        r_ramaddr  <= daddr;
        r_ramstore <= dstore;
      end else if (r_state == IDLE && w_gnt_i) begin
        r_last    <= GRANT_I;
        r_ramren  <= 1'b1;
        r_ramwen  <= 1'b0;
        r_ramaddr <= iaddr;
      end else if (w_busy && (ramready || w_expired)) begin
        r_ramren <= 1'b0;
        r_ramwen <= 1'b0;
        if (ramready && r_state == IBUSY) r_iload <= ramload;
        if (ramready && r_state == DBUSY) r_dload <= ramload;
      end
    end
  end
  always_comb begin
    iwait  = iREN & (r_state != IDONE);
    dwait  = w_dreq & (r_state != DDONE);
    halted = r_halt_seen & (r_state == IDLE) & ~w_dreq;
  end
  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign iload    = r_iload;
  assign dload    = r_dload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and a randomized run against a RAM/requester model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, RST, halt, iREN, dREN, dWEN, ramready;
  word_t iaddr, daddr, dstore, ramload, iload, dload, ramaddr, ramstore;
  logic iwait, dwait, ramREN, ramWEN, halted;
`ifdef MEMARB_TIMEOUT_EN
  logic err;
`endif
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .halt(halt), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramready(ramready), .halted(halted)
`ifdef MEMARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  typedef struct {
    logic [4:0] ctl;
    word_t ia, da, ds, rl;
    logic [3:0] e;
    word_t ea, es, eil, edl;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  logic i_act, d_act, d_wr, d_both, acc_on, acc_wr, prev_i, prev_d, free_prev, busy_now, strobes;
  word_t i_a, d_a, d_d, acc_addr, acc_data, exp_il, exp_dl;
  word_t mem [16];
  word_t got_seq[$];
  word_t alt_exp [6] = '{32'h400, 32'h300, 32'h400, 32'h300, 32'h400, 32'h300};
  int i_gap, d_gap, last_side, acc_side, acc_cnt, acc_lat, done_now, done_next;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    // ctl = {RST,iREN,dREN,dWEN,ramready}; e = {ramREN,ramWEN,iwait,dwait}
    vt.push_back('{5'b01000, 32'h100, 0, 0, 0, 4'b0010, 0, 0, 0, 0});
    vt.push_back('{5'b01000, 32'h100, 0, 0, 0, 4'b1010, 32'h100, 0, 0, 0});
    vt.push_back('{5'b01001, 32'h100, 0, 0, 32'h3C010001, 4'b1010, 32'h100, 0, 0, 0});
    vt.push_back('{5'b01000, 32'h100, 0, 0, 0, 4'b0000, 32'h100, 0, 32'h3C010001, 0});
    vt.push_back('{5'b00000, 0, 0, 0, 0, 4'b0000, 32'h100, 0, 32'h3C010001, 0});
    vt.push_back('{5'b00010, 0, 32'h80, 32'hDEADBEEF, 0, 4'b0001, 32'h100, 0, 32'h3C010001, 0});
    vt.push_back('{5'b00011, 0, 32'h80, 32'hDEADBEEF, 0, 4'b0101, 32'h80, 32'hDEADBEEF, 32'h3C010001, 0});
    vt.push_back('{5'b00010, 0, 32'h80, 32'hDEADBEEF, 0, 4'b0000, 32'h80, 32'hDEADBEEF, 32'h3C010001, 0});
    vt.push_back('{5'b00000, 0, 0, 0, 0, 4'b0000, 32'h80, 32'hDEADBEEF, 32'h3C010001, 0});
    vt.push_back('{5'b10000, 0, 0, 0, 0, 4'b0000, 32'h80, 32'hDEADBEEF, 32'h3C010001, 0});
    vt.push_back('{5'b01100, 32'h104, 32'h200, 0, 0, 4'b0011, 0, 0, 0, 0});
    vt.push_back('{5'b01101, 32'h104, 32'h200, 0, 32'hAAAA5555, 4'b1011, 32'h200, 0, 0, 0});
    vt.push_back('{5'b01100, 32'h104, 32'h200, 0, 0, 4'b0010, 32'h200, 0, 0, 32'hAAAA5555});
    vt.push_back('{5'b01000, 32'h104, 0, 0, 0, 4'b0010, 32'h200, 0, 0, 32'hAAAA5555});
    vt.push_back('{5'b01001, 32'h104, 0, 0, 32'h11112222, 4'b1010, 32'h104, 0, 0, 32'hAAAA5555});
    vt.push_back('{5'b01000, 32'h104, 0, 0, 0, 4'b0000, 32'h104, 0, 32'h11112222, 32'hAAAA5555});
    vt.push_back('{5'b00001, 0, 0, 0, 32'hFFFFFFFF, 4'b0000, 32'h104, 0, 32'h11112222, 32'hAAAA5555});
    vt.push_back('{5'b00000, 0, 0, 0, 0, 4'b0000, 32'h104, 0, 32'h11112222, 32'hAAAA5555});

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      {RST, iREN, dREN, dWEN, ramready} = vt[i].ctl;
      iaddr = vt[i].ia; daddr = vt[i].da; dstore = vt[i].ds; ramload = vt[i].rl;
      #1;
      chk($sformatf("vec%0d_flags", i), 32'({ramREN, ramWEN, iwait, dwait}), 32'(vt[i].e));
      chk($sformatf("vec%0d_ramaddr", i), ramaddr, vt[i].ea);
      chk($sformatf("vec%0d_ramstore", i), ramstore, vt[i].es);
      chk($sformatf("vec%0d_iload", i), iload, vt[i].eil);
      chk($sformatf("vec%0d_dload", i), dload, vt[i].edl);
      chk1($sformatf("vec%0d_halted", i), halted, 1'b0);
      @(negedge CLK);
    end

    // Continuous dual requests: grants must alternate starting with data.
    do_reset();
    for (int k = 0; k < 60 && got_seq.size() < 6; k++) begin
      iREN = 1'b1; dREN = 1'b1; iaddr = 32'h300; daddr = 32'h400;
      ramready = ramREN; ramload = word_t'(k);
      #1;
      if (ramREN) got_seq.push_back(ramaddr);
      @(negedge CLK);
    end
    chk("alt_count", word_t'(got_seq.size()), 6);
    for (int k = 0; k < got_seq.size() && k < 6; k++) chk($sformatf("alt_grant%0d", k), got_seq[k], alt_exp[k]);

    // Halt during a fetch: fetch drains, new fetches blocked, data still served.
    do_reset();
    iREN = 1'b1; iaddr = 32'h500; #1; @(negedge CLK);
    halt = 1'b1; #1;
    chk1("halt_busy_ren", ramREN, 1'b1); chk("halt_busy_addr", ramaddr, 32'h500);
    @(negedge CLK);
    halt = 1'b0; ramready = 1'b1; ramload = 32'hCAFEF00D; #1; @(negedge CLK);
    ramready = 1'b0; #1;
    chk1("halt_idone_iwait", iwait, 1'b0); chk("halt_iload", iload, 32'hCAFEF00D); chk1("halt_idone_halted", halted, 1'b0);
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1($sformatf("halt_block%0d_ren", k), ramREN, 1'b0);
      chk1($sformatf("halt_block%0d_iwait", k), iwait, 1'b1);
      chk1($sformatf("halt_block%0d_halted", k), halted, 1'b1);
      @(negedge CLK);
    end
    dREN = 1'b1; daddr = 32'h600; #1;
    chk1("halt_dreq_halted", halted, 1'b0); chk1("halt_dreq_dwait", dwait, 1'b1);
    @(negedge CLK);
    ramready = 1'b1; ramload = 32'h77; #1;
    chk1("halt_dbusy_ren", ramREN, 1'b1); chk("halt_dbusy_addr", ramaddr, 32'h600); chk1("halt_dbusy_halted", halted, 1'b0);
    @(negedge CLK);
    ramready = 1'b0; #1;
    chk1("halt_ddone_dwait", dwait, 1'b0); chk("halt_dload", dload, 32'h77);
    @(negedge CLK);
    dREN = 1'b0; #1;
    chk1("halt_after_halted", halted, 1'b1); chk1("halt_after_ren", ramREN, 1'b0);
    @(negedge CLK);

    // Withdrawal mid-access, then reset mid-access.
    do_reset();
    iREN = 1'b1; iaddr = 32'h900; #1; @(negedge CLK);
    iREN = 1'b0; #1;
    chk1("wd_busy_ren", ramREN, 1'b1); chk1("wd_busy_iwait", iwait, 1'b0);
    @(negedge CLK);
    ramready = 1'b1; ramload = 32'h5A5A; #1; @(negedge CLK);
    ramready = 1'b0; #1;
    chk("wd_iload", iload, 32'h5A5A); chk1("wd_done_ren", ramREN, 1'b0);
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'hA00; #1; @(negedge CLK);
    RST = 1'b1; #1;
    chk1("rstmid_busy_ren", ramREN, 1'b1); chk("rstmid_busy_addr", ramaddr, 32'hA00);
    @(negedge CLK);
    RST = 1'b0; iREN = 1'b0; ramready = 1'b1; ramload = 32'hBAD; #1;
    chk1("rstmid_ren", ramREN, 1'b0); chk("rstmid_addr", ramaddr, 0);
    @(negedge CLK);
    ramready = 1'b0; #1;
    chk("rstmid_iload", iload, 0); chk1("rstmid_ren2", ramREN, 1'b0);
    @(negedge CLK);

`ifdef MEMARB_TIMEOUT_EN
    do_reset();
    dREN = 1'b1; daddr = 32'h700; #1; @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1($sformatf("to_busy%0d_ren", k), ramREN, 1'b1); chk1($sformatf("to_busy%0d_err", k), err, 1'b0);
      @(negedge CLK);
    end
    #1;
    chk1("to_ren", ramREN, 1'b0); chk1("to_err", err, 1'b1); chk1("to_dwait", dwait, 1'b1);
    @(negedge CLK);
    do_reset();
    #1;
    chk1("to_err_cleared", err, 1'b0);
    @(negedge CLK);
`endif

    // Randomized traffic against a RAM + requester model.
    do_reset();
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    i_act = 0; d_act = 0; d_wr = 0; d_both = 0; i_gap = 0; d_gap = 0;
    i_a = 0; d_a = 0; d_d = 0; acc_on = 0; acc_wr = 0; acc_addr = 0; acc_data = 0;
    prev_i = 0; prev_d = 0; free_prev = 0; last_side = 0; done_now = -1;
    exp_il = 0; exp_dl = 0; acc_side = 0; acc_cnt = 0; acc_lat = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      done_next = -1;
      strobes = ramREN | ramWEN;
      chk("rnd_iload", iload, exp_il);
      chk("rnd_dload", dload, exp_dl);
      if (!acc_on) begin
        chk1("rnd_grant", strobes, free_prev & (prev_i | prev_d));
        if (strobes && free_prev && (prev_i || prev_d)) begin
          acc_side = (prev_i && prev_d) ? 1 - last_side : (prev_d ? 1 : 0);
          last_side = acc_side;
          acc_wr = (acc_side == 1) ? d_wr : 1'b0;
          acc_addr = (acc_side == 1) ? d_a : i_a;
          acc_data = d_d;
          acc_on = 1; acc_cnt = 0; acc_lat = $urandom_range(0, 3);
        end
      end
      if (acc_on) begin
        chk1("rnd_ren", ramREN, ~acc_wr);
        chk1("rnd_wen", ramWEN, acc_wr);
        chk("rnd_addr", ramaddr, acc_addr);
        if (acc_wr) chk("rnd_store", ramstore, acc_data);
      end
      busy_now = acc_on;
      if (acc_on && acc_cnt == acc_lat) begin
        ramready = 1'b1;
        if (acc_wr) begin
          ramload = $urandom;
          mem[acc_addr[5:2]] = acc_data;
        end else ramload = mem[acc_addr[5:2]];
        if (acc_side == 1) exp_dl = ramload; else exp_il = ramload;
        done_next = acc_side;
        acc_on = 0;
      end else begin
        ramready = !acc_on && ($urandom_range(0, 3) == 0);
        ramload = $urandom;
        if (acc_on) acc_cnt++;
      end
      if (!i_act) begin
        if (i_gap > 0) i_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          i_act = 1; i_a = 32'h1000 | ($urandom & 32'h3C);
        end
      end
      if (!d_act) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          d_act = 1; d_wr = $urandom_range(0, 1) == 1; d_both = d_wr && ($urandom_range(0, 1) == 1);
          d_a = 32'h2000 | ($urandom & 32'h3C); d_d = $urandom;
        end
      end
      iREN = i_act; iaddr = i_a;
      dWEN = d_act & d_wr; dREN = d_act & (~d_wr | d_both); daddr = d_a; dstore = d_d;
      #1;
      chk1("rnd_iwait", iwait, i_act && done_now != 0);
      chk1("rnd_dwait", dwait, d_act && done_now != 1);
      chk1("rnd_halted", halted, 1'b0);
      prev_i = i_act; prev_d = d_act;
      free_prev = !busy_now && done_now < 0;
      if (done_now == 0) begin i_act = 0; i_gap = $urandom_range(0, 2); end
      if (done_now == 1) begin d_act = 0; d_gap = $urandom_range(0, 2); end
      done_now = done_next;
      @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
